conv_seq_ctrl: RTL and testbench

- Sequencer for the 3x3 line-buffer convolver. Loads the 9 filter taps from a ready/valid filter stream, then streams one image from a ready/valid pixel source.
- Sequences the convolver's control inputs: shifting_filter, shifting_line, line_buffer_reset, row_length and mac_enable.
- Re-times output_mac into a qualified result stream carrying only the (W-2)x(H-2) valid-window outputs.
- Sits between the layer scheduler (start/dims) and one convolver instance.

---
 rtl/conv_seq_pkg.sv | 20 ++
 rtl/conv_seq_out_track.sv | 71 +++++++
 rtl/conv_seq_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared definitions for the 3x3 convolver sequencer: state codes, minimum
// image dimension, default tap count and the line-buffer fill length.
package conv_seq_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD_FLT = 3'd1;
  localparam logic [2:0] ST_FILL     = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam int MIN_DIM      = 4;
  localparam int FLT_TAPS_DEF = 9;

  // Pixels needed before the first full 3x3 window: two rows plus three.
  function automatic logic [31:0] fill_len(input logic [31:0] w);
    return (w << 1) + 32'd3;
  endfunction

endpackage

// File: rtl/conv_seq_out_track.sv
// Tracks which mac_enable cycles produce a valid 3x3 window and re-times
// that qualification by MAC_LAT cycles to line up with output_mac.
module conv_seq_out_track
  import conv_seq_pkg::*;
#(
  parameter int DIM_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_clr_i,
  input  logic             flush_i,
  input  logic             mac_en_i,
  input  logic [DIM_W-1:0] w_i,
  input  logic [DIM_W-1:0] h_i,
  output logic             out_valid_o,
  output logic             out_last_o
);

  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO   = DIM_W'(2);
  localparam logic [DIM_W-1:0] THREE = DIM_W'(3);

  logic [DIM_W-1:0] c_q, r_q;
  logic [MAC_LAT-1:0] vld_p;
  logic [DIM_W-1:0] c_p [MAC_LAT];
  logic [DIM_W-1:0] r_p [MAC_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= '0;
      r_q <= '0;
    end else if (cnt_clr_i) begin
      c_q <= '0;
      r_q <= '0;
    end else if (mac_en_i) begin
      if (c_q == w_i - ONE) begin
        c_q <= '0;
        r_q <= r_q + ONE;
      end else begin
        c_q <= c_q + ONE;
      end
    end
  end

  // Stage boundary: window position travels MAC_LAT cycles with its enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else if (flush_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= mac_en_i;
      for (int i = 1; i < MAC_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    c_p[0] <= c_q;
    r_p[0] <= r_q;
    for (int i = 1; i < MAC_LAT; i++) begin
      c_p[i] <= c_p[i-1];
      r_p[i] <= r_p[i-1];
    end
  end

  assign out_valid_o = vld_p[MAC_LAT-1] && (c_p[MAC_LAT-1] < w_i - TWO);
  assign out_last_o  = out_valid_o && (r_p[MAC_LAT-1] == h_i - THREE) &&
                       (c_p[MAC_LAT-1] == w_i - THREE);

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for one 3x3 line-buffer convolver: loads taps, streams one image,
// qualifies results. Define CONV_SEQ_CTRL_PERF_EN to add perf counters.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 36,
  parameter int DIM_W    = 8,
  parameter int FLT_TAPS = FLT_TAPS_DEF,
  parameter int MAC_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              flt_valid,
  output logic              flt_ready,
  input  logic [DATA_W-1:0] flt_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  output logic              shifting_filter,
  output logic [DATA_W-1:0] input_filter,
  output logic              shifting_line,
  output logic              line_buffer_reset,
  output logic [DIM_W-1:0]  row_length,
  output logic [DATA_W-1:0] input_line,
  output logic              mac_enable,
  input  logic [ACC_W-1:0]  output_mac,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last
`ifdef CONV_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_flt_stall
`endif
);

  localparam int CW  = 2 * DIM_W;
  localparam int FCW = $clog2(FLT_TAPS + 1);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pix_cnt_q, tot_pix_q, fill_len_q, run_len_q;
  logic [FCW-1:0]   flt_cnt_q;
  logic [DIM_W-1:0] w_q, h_q, row_len_q;
  logic             err_q, err_d;
  logic             dims_ok, job_go, underrun, pix_acc, trk_clr;

  assign dims_ok = (img_w >= DIM_W'(MIN_DIM)) && (img_h >= DIM_W'(MIN_DIM));
  assign job_go  = (state_q == ST_IDLE) && start && dims_ok;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    err_d             = 1'b0;
    busy              = (state_q != ST_IDLE);
    done              = 1'b0;
    flt_ready         = 1'b0;
    shifting_filter   = 1'b0;
    shifting_line     = 1'b0;
    line_buffer_reset = 1'b0;
    pix_ready         = 1'b0;
    mac_enable        = 1'b0;
    underrun          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        line_buffer_reset = 1'b1;
        cnt_d             = '0;
        if (start) begin
          if (dims_ok) state_d = ST_LOAD_FLT;
          else         err_d   = 1'b1;
        end
      end
      ST_LOAD_FLT: begin
        flt_ready         = 1'b1;
        shifting_filter   = flt_valid;
        line_buffer_reset = 1'b1;
        if (flt_valid && (flt_cnt_q == FCW'(FLT_TAPS - 1))) state_d = ST_FILL;
      end
      ST_FILL: begin
        pix_ready     = 1'b1;
        underrun      = !pix_valid;
        shifting_line = !underrun;
        if (underrun) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == fill_len_q - 1'b1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Once the whole image is in, the last cycles shift zeros.
        pix_ready     = (pix_cnt_q < tot_pix_q);
        underrun      = pix_ready && !pix_valid;
        shifting_line = !underrun;
        mac_enable    = !underrun;
        if (underrun) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == run_len_q - 1'b1) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(MAC_LAT - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pix_acc      = pix_ready && pix_valid;
  assign input_line   = pix_acc ? pix_data : '0;
  assign input_filter = flt_data;
  assign row_length   = row_len_q;
  assign err          = err_q;
  assign trk_clr      = (state_q == ST_FILL);
  assign out_data     = out_valid ? output_mac : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q        <= '0;
      h_q        <= '0;
      row_len_q  <= '0;
      fill_len_q <= '0;
      run_len_q  <= '0;
      tot_pix_q  <= '0;
    end else if (job_go) begin
      w_q        <= img_w;
      h_q        <= img_h;
      row_len_q  <= img_w - DIM_W'(3);
      fill_len_q <= CW'(fill_len(32'(img_w)));
      run_len_q  <= (CW'(img_h) - CW'(2)) * CW'(img_w);
      tot_pix_q  <= CW'(img_h) * CW'(img_w);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      flt_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      if ((state_q == ST_LOAD_FLT) && flt_valid) flt_cnt_q <= flt_cnt_q + 1'b1;
      if (pix_acc) pix_cnt_q <= pix_cnt_q + 1'b1;
    end
  end

  conv_seq_out_track #(
    .DIM_W   (DIM_W),
    .MAC_LAT (MAC_LAT)
  ) u_track (
    .clk         (clk),
    .rst         (rst),
    .cnt_clr_i   (trk_clr),
    .flush_i     (underrun),
    .mac_en_i    (mac_enable),
    .w_i         (w_q),
    .h_i         (h_q),
    .out_valid_o (out_valid),
    .out_last_o  (out_last)
  );

`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0] busy_cyc_q, perf_cycles_q;
  logic [15:0] flt_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cyc_q    <= '0;
      perf_cycles_q <= '0;
      flt_stall_q   <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        busy_cyc_q <= '0;
        if (job_go) flt_stall_q <= '0;
      end else begin
        busy_cyc_q <= busy_cyc_q + 32'd1;
      end
      if ((state_q == ST_LOAD_FLT) && !flt_valid) flt_stall_q <= flt_stall_q + 16'd1;
      // The DONE cycle itself is still a busy cycle.
      if (state_q == ST_DONE) perf_cycles_q <= busy_cyc_q + 32'd1;
    end
  end

  assign perf_cycles    = perf_cycles_q;
  assign perf_flt_stall = flt_stall_q;
`else
  // Perf counters not built in this configuration.
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized directed bench for conv_seq_ctrl with a behavioural convolver
// and a 2-D convolution reference computed from the driven image and taps.
module tb_conv_seq_ctrl;

  localparam int DATA_W  = 16;
  localparam int ACC_W   = 36;
  localparam int DIM_W   = 8;
  localparam int MAC_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  img_w = '0, img_h = '0;
  logic              busy, done, err;
  logic              flt_valid = 1'b0, flt_ready;
  logic [DATA_W-1:0] flt_data = '0;
  logic              pix_valid = 1'b0, pix_ready;
  logic [DATA_W-1:0] pix_data = '0;
  logic              shifting_filter, shifting_line, line_buffer_reset, mac_enable;
  logic [DATA_W-1:0] input_filter, input_line;
  logic [DIM_W-1:0]  row_length;
  logic [ACC_W-1:0]  output_mac = '0;
  logic              out_valid, out_last;
  logic [ACC_W-1:0]  out_data;
`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0]       perf_cycles;
  logic [15:0]       perf_flt_stall;
`endif

  int    ncmp  = 0;
  int    nfail = 0;
  string job   = "reset";

  conv_seq_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .DIM_W(DIM_W), .FLT_TAPS(9), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .busy(busy), .done(done), .err(err),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .shifting_filter(shifting_filter), .input_filter(input_filter),
    .shifting_line(shifting_line), .line_buffer_reset(line_buffer_reset),
    .row_length(row_length), .input_line(input_line), .mac_enable(mac_enable),
    .output_mac(output_mac), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last)
`ifdef CONV_SEQ_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_flt_stall(perf_flt_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s/%s: observed %0d expected %0d", job, tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".lbr"}, line_buffer_reset, 1);
    chk({tag, ".flt_ready"}, flt_ready, 0);
    chk({tag, ".pix_ready"}, pix_ready, 0);
    chk({tag, ".shift_f"}, shifting_filter, 0);
    chk({tag, ".shift_l"}, shifting_line, 0);
    chk({tag, ".mac_en"}, mac_enable, 0);
    chk({tag, ".row_len"}, row_length, 0);
    chk({tag, ".in_line"}, input_line, 0);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".out_last"}, out_last, 0);
  endtask

  // One job: start pulse at cycle 0, then bench acts as filter/pixel source
  // and as the convolver itself (line history + MAC_LAT result pipe).
  task automatic run_job(input string nm, input int w, input int h,
                         input int st_a, input int st_b, input int drop_at,
                         input int rst_at, input int sa_cyc, input bit ident);
    int     img[];
    int     fl[9];
    longint expq[$];
    longint hist[$];
    longint frec[$];
    longint pd[MAC_LAT];
    bit     pvv[MAC_LAT];
    longint v;
    bit     legal;
    int     base, nxt, facc;
    int     sf_n, last_facc, first_sl, first_mac, mac_n, pix_n, out_n, first_out;
    int     last_out_cyc, last_idx, done_cyc, drop_cyc, err_cyc, done_n, err_n;
    int     late_out, busy_n;
    job = nm;
    legal = (w >= 4) && (h >= 4);
    nxt = 0; facc = 0; sf_n = 0; last_facc = -1; first_sl = -1; first_mac = -1;
    mac_n = 0; pix_n = 0; out_n = 0; first_out = -1; last_out_cyc = -1;
    last_idx = -1; done_cyc = -1; drop_cyc = -1; err_cyc = -1; done_n = 0;
    err_n = 0; late_out = 0; busy_n = 0;
    for (int k = 0; k < MAC_LAT; k++) begin pd[k] = 0; pvv[k] = 1'b0; end
    img = new[w * h];
    for (int i = 0; i < w * h; i++) img[i] = ident ? (i & 16'hFFFF) : int'($urandom_range(0, 255));
    for (int k = 0; k < 9; k++) fl[k] = ident ? ((k == 4) ? 1 : 0) : int'($urandom_range(0, 15));
    if (legal)
      for (int r = 0; r < h - 2; r++)
        for (int c = 0; c < w - 2; c++) begin
          v = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) v += longint'(fl[3*i+j]) * img[(r+i)*w + c + j];
          expq.push_back(v);
        end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      output_mac = pvv[MAC_LAT-1] ? ACC_W'(pd[MAC_LAT-1]) : ACC_W'({$urandom, $urandom});
      start      = (cyc == 0) || (cyc == sa_cyc);
      img_w      = (cyc == sa_cyc) ? DIM_W'(w + 1) : DIM_W'(w);
      img_h      = DIM_W'(h);
      flt_valid  = (facc < 9) && (cyc != st_a) && (cyc != st_b);
      flt_data   = (facc < 9) ? DATA_W'(fl[facc]) : '0;
      pix_valid  = (nxt < w * h) && (nxt != drop_at);
      pix_data   = (nxt < w * h) ? DATA_W'(img[nxt]) : '0;
      #1;
      if (cyc == rst_at) begin
        chk("in_run_before_rst", mac_enable, 1);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1; start = 1'b0; flt_valid = 1'b0; pix_valid = 1'b0;
        #1;
        chk("post_rst.busy", busy, 0);
        chk("post_rst.lbr", line_buffer_reset, 1);
        return;
      end
      if (cyc == 0) chk("busy_at_start", busy, 0);
      if (cyc == 1 && legal) chk("busy_after_start", busy, 1);
      if (busy) busy_n++;
      if (flt_valid && flt_ready) begin facc++; last_facc = cyc; end
      if (shifting_filter) begin sf_n++; frec.push_back(longint'(input_filter)); end
      if (line_buffer_reset) hist.delete();
      v = 0;
      if (mac_enable) begin
        mac_n++;
        if (first_mac < 0) first_mac = cyc;
        base = hist.size() - (2 * w + 3);
        if (base >= 0)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              v += ((3*i+j) < frec.size() ? frec[3*i+j] : 0) * hist[base + i*w + j];
      end
      if (shifting_line) begin
        if (first_sl < 0) first_sl = cyc;
        hist.push_back(longint'(input_line));
      end
      if (pix_ready && !pix_valid && drop_cyc < 0) drop_cyc = cyc;
      if (pix_ready && pix_valid) begin nxt++; pix_n++; end
      if (out_valid) begin
        if (drop_cyc >= 0 && cyc > drop_cyc) late_out++;
        else begin
          if (first_out < 0) first_out = cyc;
          chk("out_data", out_data, (out_n < expq.size()) ? expq[out_n] : -1);
          if (out_last) begin last_idx = out_n; last_out_cyc = cyc; end
          out_n++;
        end
      end
      if (done) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
      if (err) begin err_n++; if (err_cyc < 0) err_cyc = cyc; end
      if (drop_cyc >= 0 && cyc == drop_cyc + 1) begin
        chk("abort.err", err, 1);
        chk("abort.lbr", line_buffer_reset, 1);
        chk("abort.busy", busy, 0);
        chk("abort.shift_l", shifting_line, 0);
        chk("abort.mac_en", mac_enable, 0);
      end
      for (int k = MAC_LAT - 1; k > 0; k--) begin pd[k] = pd[k-1]; pvv[k] = pvv[k-1]; end
      pd[0] = v; pvv[0] = mac_enable;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", busy, 0);
        break;
      end
      if (!legal && cyc == 10) break;
      if (drop_cyc >= 0 && cyc == drop_cyc + 12) break;
    end
    start = 1'b0;
    flt_valid = 1'b0;
    pix_valid = 1'b0;

    if (!legal) begin
      chk("bad_dims.err_cyc", err_cyc, 1);
      chk("bad_dims.err_n", err_n, 1);
      chk("bad_dims.busy_n", busy_n, 0);
      chk("bad_dims.done_n", done_n, 0);
    end else if (drop_at >= 0) begin
      chk("drop.seen", drop_cyc >= 0, 1);
      chk("drop.err_cyc", err_cyc, drop_cyc + 1);
      chk("drop.err_n", err_n, 1);
      chk("drop.done_n", done_n, 0);
      chk("drop.late_out", late_out, 0);
    end else begin
      chk("taps_shifted", sf_n, 9);
      for (int k = 0; k < 9; k++) chk("tap_value", (k < frec.size()) ? frec[k] : -1, fl[k]);
      chk("fill_start", first_sl, last_facc + 1);
      chk("row_length", row_length, w - 3);
      chk("fill_len", first_mac - first_sl, 2 * w + 3);
      chk("run_len", mac_n, (h - 2) * w);
      chk("pix_count", pix_n, w * h);
      chk("out_count", out_n, (w - 2) * (h - 2));
      chk("out_latency", first_out - first_mac, MAC_LAT);
      chk("last_index", last_idx, (w - 2) * (h - 2) - 1);
      chk("last_cycle", last_out_cyc, first_mac + (h - 2) * w - 3 + MAC_LAT);
      chk("done_cycle", done_cyc, first_mac + (h - 2) * w + MAC_LAT);
      chk("done_n", done_n, 1);
      chk("err_n", err_n, 0);
    end
  endtask

  initial begin
    int rw, rh;
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("in_reset");
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_outputs("after_release");

    run_job("ramp30", 30, 30, -1, -1, -1, -1, -1, 1'b1);
`ifdef CONV_SEQ_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, 9 + 63 + 840 + 3 + 1);
    chk("perf_flt_stall", perf_flt_stall, 0);
`endif
    run_job("flt_stall", 8, 6, 3, 7, -1, -1, 20, 1'b0);
`ifdef CONV_SEQ_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, 11 + 19 + 32 + MAC_LAT + 1);
    chk("perf_flt_stall", perf_flt_stall, 2);
`endif
    run_job("min4x4", 4, 4, -1, -1, -1, -1, -1, 1'b0);
    run_job("w3", 3, 10, -1, -1, -1, -1, -1, 1'b0);
    run_job("h3", 10, 3, -1, -1, -1, -1, -1, 1'b0);
    run_job("underrun", 30, 30, -1, -1, 100, -1, -1, 1'b0);
`ifdef CONV_SEQ_CTRL_PERF_EN
    chk("perf_held_on_abort", perf_cycles, 9 + 11 + 8 + MAC_LAT + 1);
`endif
    run_job("after_abort", 30, 30, -1, -1, -1, -1, -1, 1'b0);
    run_job("rst_mid_run", 12, 10, -1, -1, -1, 60, -1, 1'b0);
    run_job("after_rst", 12, 10, -1, -1, -1, -1, -1, 1'b0);
    rw = $urandom_range(4, 16);
    rh = $urandom_range(4, 12);
    run_job("random_dims", rw, rh, -1, -1, -1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
